// File: rtl/jpeg_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_quantizer
// Purpose  : Streaming JPEG coefficient quantizer. Each DCT coefficient is
//            multiplied by a run-time loadable reciprocal from one of
//            NUM_TABLES 64-entry tables. The product is rounded half away
//            from zero and sent out on a valid/ready stream.
//            Three pipeline stages: S1 table lookup + input register,
//            S2 signed multiply, S3 round (and optionally saturate).
// Ports    : clk, rst (async, active high)
//            tbl_wr_en/sel/addr/data : reciprocal table write port
//            in_valid/in_ready/in_data/in_sel : coefficient input stream
//            out_valid/out_ready/out_data/out_last : quantized output stream
// Options  : QUANT_SAT_EN - clamp the result to the OUT_W signed range and
//            keep a sticky internal sat_seen flag. When undefined, the result
//            wraps to its low OUT_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_quantizer #(
    parameter int IN_W       = 11,
    parameter int OUT_W      = 11,
    parameter int FRAC       = 12,
    parameter int NUM_TABLES = 3,
    localparam int SEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tbl_wr_en,
    input  logic [SEL_W-1:0]       tbl_wr_sel,
    input  logic [5:0]             tbl_wr_addr,
    input  logic [FRAC:0]          tbl_wr_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_last
);

    localparam int P_W   = IN_W + FRAC + 2;   // product width
    localparam int M_W   = P_W - FRAC;        // rounded magnitude width
    localparam int R_W   = M_W + 1;           // signed result width
    localparam int N_ENT = NUM_TABLES * 64;

    localparam logic [FRAC:0]    c_recip_one = {1'b1, {FRAC{1'b0}}};
    localparam logic [P_W-1:0]   c_half      = {{(P_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic [SEL_W:0]   c_ntbl      = NUM_TABLES[SEL_W:0];

    // ------------------------------------------------------------------
    // Reciprocal tables
    // ------------------------------------------------------------------
    logic [FRAC:0]    r_tbl [N_ENT];
    logic [SEL_W+5:0] w_wr_ent;
    logic             w_wr_ok;

    assign w_wr_ent = {tbl_wr_sel, tbl_wr_addr};
    assign w_wr_ok  = ({1'b0, tbl_wr_sel} < c_ntbl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) begin
                r_tbl[i] <= c_recip_one;
            end
        end else if (tbl_wr_en && w_wr_ok) begin
            r_tbl[w_wr_ent] <= tbl_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Handshake, coefficient counter and block table selection
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic             w_stall;
    logic             w_acc;
    logic [5:0]       r_idx;
    logic [SEL_W-1:0] r_blk_sel;
    logic [SEL_W-1:0] w_in_sel_ok;
    logic [SEL_W-1:0] w_sel;
    logic [SEL_W+5:0] w_rd_ent;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_acc    = in_valid && !w_stall;

    // Out-of-range selections fall back to table 0.
    assign w_in_sel_ok = ({1'b0, in_sel} < c_ntbl) ? in_sel : '0;
    // Coefficient 0 looks up with the live in_sel; the rest use the latched one.
    assign w_sel       = (r_idx == 6'd0) ? w_in_sel_ok : r_blk_sel;
    assign w_rd_ent    = {w_sel, r_idx};

    // ------------------------------------------------------------------
    // S1: table lookup + input register
    // ------------------------------------------------------------------
    logic                   r_s1_valid;
    logic signed [IN_W-1:0] r_s1_data;
    logic [FRAC:0]          r_s1_recip;
    logic                   r_s1_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= 6'd0;
            r_blk_sel  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_recip <= '0;
            r_s1_last  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_idx <= r_idx + 6'd1;
                if (r_idx == 6'd0) begin
                    r_blk_sel <= w_in_sel_ok;
                end
            end
            if (!w_stall) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data  <= in_data;
                    r_s1_recip <= r_tbl[w_rd_ent];
                    r_s1_last  <= (r_idx == 6'd63);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: signed multiply (reciprocal zero-extended to a positive operand)
    // ------------------------------------------------------------------
    logic                  r_s2_valid;
    logic signed [P_W-1:0] r_s2_prod;
    logic                  r_s2_last;
    logic signed [FRAC+1:0] w_recip_s;

    assign w_recip_s = {1'b0, r_s1_recip};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_last  <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod <= r_s1_data * w_recip_s;
                r_s2_last <= r_s1_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: round half away from zero on the magnitude, then restore sign
    // ------------------------------------------------------------------
    logic                  w_neg;
    logic [P_W-1:0]        w_abs;
    logic [P_W-1:0]        w_sum;
    logic [M_W-1:0]        w_mag;
    logic signed [R_W-1:0] w_res;
    logic [OUT_W-1:0]      w_q;
    logic                  w_unused_bits;

    assign w_neg = r_s2_prod[P_W-1];
    assign w_abs = w_neg ? -r_s2_prod : r_s2_prod;
    assign w_sum = w_abs + c_half;
    assign w_mag = w_sum[P_W-1:FRAC];
    assign w_res = w_neg ? -{1'b0, w_mag} : {1'b0, w_mag};

`ifdef QUANT_SAT_EN
    localparam logic signed [R_W-1:0] c_max = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] c_min = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic w_hi;
    logic w_lo;
    logic r_sat_seen;

    assign w_hi          = (w_res > c_max);
    assign w_lo          = (w_res < c_min);
    assign w_q           = w_hi ? c_max[OUT_W-1:0] :
                           w_lo ? c_min[OUT_W-1:0] : w_res[OUT_W-1:0];
    assign w_unused_bits = ^{w_sum[FRAC-1:0], r_sat_seen};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_seen <= 1'b0;
        end else if (!w_stall && r_s2_valid && (w_hi || w_lo)) begin
            r_sat_seen <= 1'b1;
        end
    end
`else
    assign w_q           = w_res[OUT_W-1:0];
    assign w_unused_bits = ^{w_sum[FRAC-1:0], w_res[R_W-1:OUT_W]};
`endif

    logic [OUT_W-1:0] r_out_data;
    logic             r_out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s2_valid;
            r_out_last  <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                r_out_data <= w_q;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_quantizer
// Purpose  : Self-checking bench for jpeg_quantizer. A reference model of the
//            table contents, coefficient counter and quantization arithmetic
//            predicts every output; a monitor compares each transfer, the
//            hold behaviour under backpressure and the transfer timing.
//            Directed vectors also carry hand-computed literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_quantizer;

    logic               clk = 1'b0;
    logic               rst;
    logic               tbl_wr_en;
    logic [1:0]         tbl_wr_sel;
    logic [5:0]         tbl_wr_addr;
    logic [12:0]        tbl_wr_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] in_data;
    logic [1:0]         in_sel;
    logic               out_valid;
    logic               out_ready;
    logic signed [10:0] out_data;
    logic               out_last;

    always #5 clk = ~clk;

    jpeg_quantizer dut (
        .clk         (clk),
        .rst         (rst),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_sel  (tbl_wr_sel),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_data (tbl_wr_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int d;
        bit last;
        int acc;
        int st;
        bit lv;
        int lit;
    } exp_t;

    exp_t q[$];
    int   mtbl [3][64];
    int   midx = 0;
    int   mblk = 0;
    int   cyc = 0;
    int   stall_cum = 0;
    bit   prev_stall = 0;
    int   prev_data = 0;
    int   prev_last = 0;
    bit   lit_v = 0;
    int   lit_val = 0;

    function automatic int model_q(input int x, input int r);
        longint p;
        longint a;
        int     m;
        int     res;
        logic [10:0] w;
        p   = longint'(x) * longint'(r);
        a   = (p < 0) ? -p : p;
        m   = int'((a + 2048) / 4096);
        res = (p < 0) ? -m : m;
`ifdef QUANT_SAT_EN
        if (res > 1023)  res = 1023;
        if (res < -1024) res = -1024;
        return res;
`else
        w = res[10:0];
        return int'($signed(w));
`endif
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 3; t++)
            for (int a = 0; a < 64; a++)
                mtbl[t][a] = 4096;
        midx = 0;
        mblk = 0;
        q.delete();
        prev_stall = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        exp_t e;
        int   sel;
        if (rst) begin
            model_reset();
        end else begin
            cyc++;
            chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), prev_data);
                chk("hold_last", int'(out_last), prev_last);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", int'(out_data), e.d);
                    chk("out_last", int'(out_last), int'(e.last));
                    chk("out_cycle", cyc, e.acc + 3 + (stall_cum - e.st));
                    if (e.lv) chk("out_literal", int'(out_data), e.lit);
                end
            end
            if (in_valid && in_ready) begin
                if (midx == 0) begin
                    sel  = (int'(in_sel) < 3) ? int'(in_sel) : 0;
                    mblk = sel;
                end
                e.d    = model_q(int'(in_data), mtbl[mblk][midx]);
                e.last = (midx == 63);
                e.acc  = cyc;
                e.st   = stall_cum;
                e.lv   = lit_v;
                e.lit  = lit_val;
                q.push_back(e);
                midx = (midx + 1) % 64;
            end
            if (tbl_wr_en && int'(tbl_wr_sel) < 3)
                mtbl[tbl_wr_sel][tbl_wr_addr] = int'(tbl_wr_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(out_data);
            prev_last  = int'(out_last);
            if (out_valid && !out_ready) stall_cum++;
        end
    end

    // ------------------------------------------------------------------
    // Drivers: every task starts and ends 1 time unit after a rising edge
    // ------------------------------------------------------------------
    task automatic send(input int d, input int sel, input bit lv, input int lit);
        int  n;
        bit  acc;
        in_valid = 1'b1;
        in_data  = d[10:0];
        in_sel   = sel[1:0];
        lit_v    = lv;
        lit_val  = lit;
        n = 0;
        acc = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        lit_v    = 1'b0;
    endtask

    task automatic wr(input int sel, input int addr, input int data);
        tbl_wr_en   = 1'b1;
        tbl_wr_sel  = sel[1:0];
        tbl_wr_addr = addr[5:0];
        tbl_wr_data = data[12:0];
        @(posedge clk);
        #1;
        tbl_wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    function automatic int pat(input int i, input int seed);
        return ((i * 73 + seed * 31) % 2047) - 1023;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv[4];
        int rl[4];
        int d;
        rv = '{100, -40, 24, -8};
        rl = '{6, -3, 2, -1};
        rst = 1'b1;
        tbl_wr_en = 0; tbl_wr_sel = 0; tbl_wr_addr = 0; tbl_wr_data = 0;
        in_valid = 0; in_data = 0; in_sel = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Default tables: identity
        for (int i = 0; i < 64; i++) send(i - 32, 0, 1, i - 32);
        drain();

        // Rounding with Cb = 256 (Q = 16), bubbles and writes during the block
        for (int a = 0; a < 64; a++) wr(1, a, 256);
        for (int i = 0; i < 64; i++) begin
            if (i < 4) begin
                send(rv[i], 1, 1, rl[i]);
            end else if (i == 10) begin
                tbl_wr_en = 1; tbl_wr_sel = 1; tbl_wr_addr = 6'd10; tbl_wr_data = 13'd512;
                send(100, 1, 1, 6);
                tbl_wr_en = 0;
            end else if (i == 12) begin
                tbl_wr_en = 1; tbl_wr_sel = 1; tbl_wr_addr = 6'd20; tbl_wr_data = 13'd512;
                send(pat(i, 1), 1, 0, 0);
                tbl_wr_en = 0;
            end else if (i == 20) begin
                send(100, 1, 1, 13);
            end else begin
                send(pat(i, 1), 1, 0, 0);
            end
            if (i % 9 == 5) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Backpressure mid-block, identity table
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    d = pat(i, 2);
                    send(d, 0, 1, d);
                end
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation / wrap
        wr(0, 0, 8191);
        for (int i = 0; i < 64; i++) begin
`ifdef QUANT_SAT_EN
            if (i == 0) send(1023, 0, 1, 1023);
`else
            if (i == 0) send(1023, 0, 1, -2);
`endif
            else if (i == 1) send(-1024, 0, 1, -1024);
            else send(pat(i, 3), 0, 0, 0);
        end
        for (int i = 0; i < 64; i++) begin
`ifdef QUANT_SAT_EN
            if (i == 0) send(-1024, 0, 1, -1024);
`else
            if (i == 0) send(-1024, 0, 1, 0);
`endif
            else send(pat(i, 4), 0, 0, 0);
        end
        drain();
        wr(0, 0, 4096);

        // Table switching, back-to-back blocks, in_sel toggling mid-block
        for (int a = 0; a < 64; a++) wr(2, a, 1024);
        for (int i = 0; i < 64; i++) begin
            d = (i == 0) ? 100 : (i == 1) ? 40 : pat(i, 5);
            send(d, (i == 0) ? 0 : (i % 4), 1, d);
        end
        for (int i = 0; i < 64; i++) begin
            if (i == 0) send(100, 2, 1, 25);
            else if (i == 1) send(40, 0, 1, 10);
            else send(pat(i, 6), i % 4, 0, 0);
        end
        for (int i = 0; i < 64; i++) begin
            d = (i == 0) ? 100 : (i == 1) ? 40 : pat(i, 7);
            send(d, (i == 0) ? 3 : 2, 1, d);
        end
        drain();

        // Reset mid-block
        for (int i = 0; i < 20; i++) send(pat(i, 8), 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_last", int'(out_last), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            d = pat(i, 9);
            send(d, 1, 1, d);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
